// File: rtl/memory_reader_pkg.sv
// memory_reader_pkg: shared widths, FSM state type and FIFO occupancy helper for memory_reader
package memory_reader_pkg;
  localparam int ADDR_WIDTH = 15;
  localparam int DATA_WIDTH = 9;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  function automatic logic [CNT_W:0] occupancy(input logic [CNT_W-1:0] cnt, input logic v1, v2, pop);
    return {1'b0, cnt} + (CNT_W+1)'(v1) + (CNT_W+1)'(v2) - (CNT_W+1)'(pop);
  endfunction
endpackage

// File: rtl/memory_reader_if.sv
// memory_reader_if: control (start/start_addr/len/abort/busy/done), SRAM (ceb/web/a/q) and stream (dout/dout_vld/dout_rdy/dout_last) signals
interface memory_reader_if;
  import memory_reader_pkg::*;
  logic start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH:0] len;
  logic abort;
  logic busy;
  logic done;
  logic ceb;
  logic web;
  logic [ADDR_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] q;
  logic [DATA_WIDTH-1:0] dout;
  logic dout_vld;
  logic dout_rdy;
  logic dout_last;
  modport slave (
    input start, start_addr, len, abort, q, dout_rdy,
    output busy, done, ceb, web, a, dout, dout_vld, dout_last
  );
  modport master (
    output start, start_addr, len, abort, q, dout_rdy,
    input busy, done, ceb, web, a, dout, dout_vld, dout_last
  );
endinterface

// File: rtl/readout_skid_fifo.sv
// readout_skid_fifo: first-word-fall-through FIFO with sync flush; ports clk/rst, flush, push/din, pop, dout/vld head, cnt occupancy
module readout_skid_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             vld,
  output logic [CW-1:0]    cnt
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr, rd;
  logic do_pop;
  always_comb begin
    vld = cnt != '0;
    do_pop = pop && vld;
    dout = vld ? mem[rd] : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else if (flush) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else begin
      wr <= wr + PW'(push);
      rd <= rd + PW'(do_pop);
      cnt <= cnt + CW'(push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr] <= din;
endmodule

// File: rtl/memory_reader.sv
// memory_reader: reads len SRAM words from start_addr (wrapping) onto a valid/ready stream; ports clk, rst, bus (memory_reader_if.slave)
module memory_reader
  import memory_reader_pkg::*;
(
  input logic            clk,
  input logic            rst,
  memory_reader_if.slave bus
);
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] addr, a_q;
  logic [ADDR_WIDTH:0] remaining;
  logic v1, l1, v2, l2, ceb_q, done_q, zero_q;
  logic abort_act, pop, accept, issue, last_issue, drained;
  logic [CNT_W-1:0] cnt;
  logic [DATA_WIDTH:0] head;
  logic head_vld;
  always_comb begin
    abort_act = bus.abort && state != IDLE;
    pop = head_vld && bus.dout_rdy && !abort_act;
    accept = state == IDLE && bus.start && !bus.abort;
    last_issue = remaining == (ADDR_WIDTH+1)'(1);
    issue = state == READ && !abort_act && remaining != '0 && occupancy(cnt, v1, v2, pop) < (CNT_W+1)'(FIFO_DEPTH);
    drained = state == DRAIN && !v1 && !v2 && cnt == CNT_W'(1) && pop;
    state_nx = abort_act ? IDLE :
               accept && bus.len != '0 ? READ :
               issue && last_issue ? DRAIN :
               state == DRAIN && done_q ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      remaining <= '0;
      a_q <= '0;
      ceb_q <= 1'b1;
      v1 <= 1'b0;
      l1 <= 1'b0;
      v2 <= 1'b0;
      l2 <= 1'b0;
      done_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state <= state_nx;
      ceb_q <= !issue;
      v1 <= issue;
      l1 <= issue && last_issue;
      v2 <= v1 && !abort_act;
      l2 <= l1;
      zero_q <= accept && bus.len == '0;
      done_q <= zero_q || drained;
      if (accept) begin
        addr <= bus.start_addr;
        remaining <= bus.len;
      end else if (issue) begin
        a_q <= addr;
        addr <= addr + ADDR_WIDTH'(1);
        remaining <= remaining - (ADDR_WIDTH+1)'(1);
      end
    end
  readout_skid_fifo #(.WIDTH(DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) fifo (
    .clk(clk),
    .rst(rst),
    .flush(abort_act),
    .push(v2 && !abort_act),
    .din({l2, bus.q}),
    .pop(pop),
    .dout(head),
    .vld(head_vld),
    .cnt(cnt)
  );
  assign bus.ceb = ceb_q;
  assign bus.web = 1'b1;
  assign bus.a = a_q;
  assign bus.busy = state != IDLE;
  assign bus.done = done_q;
  assign bus.dout = head[DATA_WIDTH-1:0];
  assign bus.dout_last = head[DATA_WIDTH];
  assign bus.dout_vld = head_vld;
endmodule
